// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART transmit arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int UART_BYTE_W     = 8;
    localparam int DEFAULT_NUM_REQ = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rr_picker.sv
// ============================================================================
// Module      : uart_rr_picker
// Description : Rotating-priority selector; lowest index at or after rr_ptr
//               (with wrap) wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               any_valid,
    output logic [ID_W-1:0]    winner
);

    assign any_valid = |req_valid;

    // Walk offsets from farthest to nearest so the nearest valid one wins.
    always_comb begin
        int w_idx;
        w_idx  = 0;
        winner = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            w_idx = int'(rr_ptr) + off;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (req_valid[w_idx]) begin
                winner = ID_W'(w_idx);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin sharing of one UART transmitter between NUM_REQ
//               byte producers. Optional busy-rise watchdog: UART_ARB_WDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ     = DEFAULT_NUM_REQ,
    parameter int ID_W        = 2,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [UART_BYTE_W-1:0]         tx_data,
    output logic                           tx_wr,
    output logic                           tx_en,
    input  logic                           tx_busy,
    output logic [ID_W-1:0]                grant_id,
    output logic                           active,
    output logic                           wdog_err
);

    arb_state_t              r_state;
    arb_state_t              w_state_next;
    logic                    r_busy_meta;
    logic                    r_busy_sync;
    logic [ID_W-1:0]         r_rr_ptr;
    logic [ID_W-1:0]         r_grant_id;
    logic [UART_BYTE_W-1:0]  r_tx_data;
    logic [ID_W-1:0]         w_winner;
    logic [ID_W-1:0]         w_rr_next;
    logic                    w_any_valid;
    logic                    w_accept;
    logic                    w_done;
    logic                    w_wdog_hit;

    uart_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req_valid (req_valid),
        .rr_ptr    (r_rr_ptr),
        .any_valid (w_any_valid),
        .winner    (w_winner)
    );

    assign w_accept  = (r_state == IDLE) && w_any_valid;
    assign w_done    = (r_state == WAIT_DONE) && !r_busy_sync;
    assign w_rr_next = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;

    // tx_busy comes from another clock domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy_meta <= 1'b0;
            r_busy_sync <= 1'b0;
        end else begin
            r_busy_meta <= tx_busy;
            r_busy_sync <= r_busy_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (w_any_valid) w_state_next = LOAD;
            LOAD:      w_state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (r_busy_sync) begin
                    w_state_next = WAIT_DONE;
                end else if (w_wdog_hit) begin
                    w_state_next = IDLE;
                end
            end
            WAIT_DONE: if (!r_busy_sync) w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    // The grant pulse is combinational so the byte is taken in the cycle it is offered.
    always_comb begin
        req_ready = '0;
        if (w_accept && !reset) begin
            req_ready[w_winner] = 1'b1;
        end
        tx_wr  = (r_state == LOAD);
        tx_en  = (r_state != IDLE);
        active = (r_state != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_data  <= '0;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
        end else begin
            if (w_accept) begin
                r_tx_data  <= req_data[UART_BYTE_W*int'(w_winner) +: UART_BYTE_W];
                r_grant_id <= w_winner;
            end
            if (w_done || w_wdog_hit) begin
                r_rr_ptr <= w_rr_next;
            end
        end
    end

    assign tx_data  = r_tx_data;
    assign grant_id = r_grant_id;

`ifdef UART_ARB_WDOG_EN
    localparam int CNT_W = $clog2(WDOG_CYCLES + 1);

    logic [CNT_W-1:0] r_wdog_cnt;
    logic             r_wdog_err;

    // Fires so the error is visible WDOG_CYCLES cycles after the tx_wr cycle.
    assign w_wdog_hit = (r_state == WAIT_BUSY) && !r_busy_sync &&
                        (r_wdog_cnt == CNT_W'(WDOG_CYCLES - 2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            if (r_state == LOAD) begin
                r_wdog_cnt <= '0;
            end else if (r_state == WAIT_BUSY) begin
                r_wdog_cnt <= r_wdog_cnt + 1'b1;
            end
            if (w_wdog_hit) begin
                r_wdog_err <= 1'b1;
            end
        end
    end

    assign wdog_err = r_wdog_err;
`else
    assign w_wdog_hit = 1'b0;
    assign wdog_err   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter with a round-robin
//               reference model and a behavioural transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_valid;
    logic [23:0] req_data;
    logic [2:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_wr;
    logic        tx_en;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        active;
    logic        wdog_err;

    int vectors     = 0;
    int miscompares = 0;
    int ptr         = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ     (3),
        .ID_W        (2),
        .WDOG_CYCLES (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_data   (tx_data),
        .tx_wr     (tx_wr),
        .tx_en     (tx_en),
        .tx_busy   (tx_busy),
        .grant_id  (grant_id),
        .active    (active),
        .wdog_err  (wdog_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: first valid requester at or after the pointer, with wrap.
    function automatic int rr_pick(input logic [2:0] v, input int p);
        for (int off = 0; off < 3; off++) begin
            if (v[(p + off) % 3]) return (p + off) % 3;
        end
        return -1;
    endfunction

    function automatic logic [2:0] onehot(input int w);
        logic [2:0] r;
        r = '0;
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_tx_wr"},     tx_wr,     0);
        chk({tag, "_tx_en"},     tx_en,     0);
        chk({tag, "_active"},    active,    0);
        chk({tag, "_grant_id"},  grant_id,  0);
        chk({tag, "_tx_data"},   tx_data,   0);
        chk({tag, "_wdog_err"},  wdog_err,  0);
    endtask

    // One complete frame starting from an IDLE cycle with req_valid already driven.
    task automatic do_frame(input int rise_dly, input int busy_len, input bit keep,
                            input bit scramble, input logic [2:0] add_mid, output int w);
        logic [7:0] b;
        bit         done;
        #1;
        w = rr_pick(req_valid, ptr);
        chk("req_ready", req_ready, onehot(w));
        chk("idle_tx_en", tx_en, 0);
        chk("idle_active", active, 0);
        if (w < 0) return;
        b = req_data[w*8 +: 8];
        if (rise_dly == 0) tx_busy = 1'b1;
        tick();
        if (!keep) req_valid[w] = 1'b0;
        req_valid = req_valid | add_mid;
        chk("tx_wr", tx_wr, 1);
        chk("tx_data", tx_data, b);
        chk("grant_id", grant_id, w);
        chk("load_tx_en", tx_en, 1);
        chk("load_ready", req_ready, 0);
        ptr  = (w + 1) % 3;
        done = 1'b0;
        for (int c = 1; c <= 60 && !done; c++) begin
            tick();
            if (!active) begin
                done = 1'b1;
            end else begin
                chk("tx_wr_once", tx_wr, 0);
                chk("busy_tx_en", tx_en, 1);
                chk("busy_ready", req_ready, 0);
                chk("hold_grant", grant_id, w);
                chk("hold_data", tx_data, b);
                if (c == rise_dly) tx_busy = 1'b1;
                if (c == rise_dly + busy_len) tx_busy = 1'b0;
                if (scramble) begin
                    req_valid = 3'($urandom);
                    req_data  = 24'($urandom);
                end
            end
        end
        chk("frame_done", done, 1);
        chk("done_tx_en", tx_en, 0);
        chk("done_tx_wr", tx_wr, 0);
        tx_busy = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        int w;
        int n;

        // Reset state, with requests already pending to prove req_ready stays low.
        reset     = 1'b1;
        req_valid = 3'b111;
        req_data  = 24'h332211;
        tx_busy   = 1'b0;
        tick();
        chk_all_zero("reset");
        tick();
        reset     = 1'b0;
        req_valid = 3'b000;
        ptr       = 0;

        // Single request from requester 1, then a full request set shows pointer at 2.
        req_valid = 3'b010;
        req_data  = {8'h33, 8'hA5, 8'h11};
        do_frame(2, 3, 1'b0, 1'b0, 3'b000, w);
        req_valid = 3'b111;
        req_data  = {8'h33, 8'h22, 8'h11};
        do_frame(1, 2, 1'b0, 1'b0, 3'b000, w);

        // Simultaneous requests held from reset: 0x11, 0x22, 0x33, 0x11.
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        ptr       = 0;
        req_valid = 3'b111;
        req_data  = {8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 4; i++) begin
            do_frame(int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), 1'b1, 1'b0, 3'b000, w);
        end

        // Fairness: requester 0 always valid, requester 2 arrives mid-frame.
        req_valid = 3'b001;
        req_data  = {8'hC2, 8'hB1, 8'hA0};
        do_frame(1, 3, 1'b1, 1'b0, 3'b100, w);
        do_frame(2, 2, 1'b0, 1'b0, 3'b000, w);
        do_frame(1, 1, 1'b1, 1'b0, 3'b000, w);

        // Busy already high on entry to WAIT_BUSY.
        req_valid = 3'b110;
        req_data  = {8'h5A, 8'h3C, 8'h00};
        do_frame(0, 4, 1'b0, 1'b0, 3'b000, w);

        // Randomised traffic with request churn while a frame is in flight.
        for (int i = 0; i < 20; i++) begin
            req_valid = 3'($urandom_range(1, 7));
            req_data  = 24'($urandom);
            do_frame(int'($urandom_range(0, 3)), int'($urandom_range(1, 6)),
                     1'($urandom_range(0, 1)), 1'b1, 3'b000, w);
        end

        // Reset while in WAIT_DONE.
        req_valid = 3'b011;
        req_data  = {8'h77, 8'h66, 8'h55};
        tick();
        req_valid = 3'b000;
        tick();
        tx_busy = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_active", active, 1);
        reset     = 1'b1;
        req_valid = 3'b100;
        #1;
        chk_all_zero("mid_reset");
        tx_busy = 1'b0;
        tick();
        reset = 1'b0;
        ptr   = 0;
        do_frame(1, 2, 1'b0, 1'b0, 3'b000, w);
        req_valid = 3'b111;
        req_data  = {8'h99, 8'h88, 8'h44};
        do_frame(1, 2, 1'b0, 1'b0, 3'b000, w);

`ifdef UART_ARB_WDOG_EN
        // Transmitter never goes busy: watchdog must fire and free the arbiter.
        req_valid = 3'b111;
        req_data  = {8'hEE, 8'hDD, 8'hCC};
        #1;
        w = rr_pick(req_valid, ptr);
        tick();
        req_valid[w] = 1'b0;
        chk("wdog_tx_wr", tx_wr, 1);
        n = 0;
        while (n < 40 && !wdog_err) begin
            tick();
            n++;
        end
        chk("wdog_latency", n, 16);
        chk("wdog_active", active, 0);
        chk("wdog_tx_en", tx_en, 0);
        ptr = (w + 1) % 3;
        do_frame(1, 2, 1'b0, 1'b0, 3'b000, w);
        chk("wdog_sticky", wdog_err, 1);
`else
        n = 0;
        chk("wdog_tied", wdog_err, n);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
